dbg_trace_unit: RTL and testbench
=================================

Name: dbg_trace_unit

Overview:
Synthesizable run-control and trace block attached to the retire stage of the processor core. It compares retiring PCs against a parametrised set of breakpoints and halts the core on a hit, a host request, or a single-step completion. Every retired instruction and its register writeback is recorded into a circular trace buffer that the host drains over a valid/ready port. It is the hardware successor to bench-side PC watching and register dumping.

Parameters:
PC_W, 16, width of program counter
INSTR_W, 16, instruction width
DATA_W, 16, register data width
REG_ADDR_W, 3, register index width (8 registers)
NUM_BP, 4, number of PC breakpoint comparators (1..8)
TRACE_DEPTH, 16, trace entries; must be a power of 2, at least 2

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
core_valid  in  1  one instruction retires this cycle
core_pc  in  PC_W  PC of retiring instruction
core_instr  in  INSTR_W  retiring instruction word
core_wr_en  in  1  retiring instruction writes a register
core_wr_addr  in  REG_ADDR_W  destination register
core_wr_data  in  DATA_W  writeback value
core_halt  out  1  registered; core must not retire while high
bp_wr_en  in  1  breakpoint configuration write strobe
bp_idx  in  clog2(NUM_BP) (min 1)  breakpoint slot
bp_addr  in  PC_W  breakpoint PC
bp_enable  in  1  slot enable value
halt_req  in  1  host halt request, 1-cycle pulse
resume_req  in  1  host resume request, 1-cycle pulse
step_req  in  1  host single-step request, 1-cycle pulse
halted  out  1  state == HALTED
halt_cause  out  3  0 NONE, 1 HOST, 2 BP, 3 STEP, 4 WATCH
trace_rd_valid  out  1  trace entry available
trace_rd_ready  in  1  host pops one entry
trace_rd_data  out  PC_W+INSTR_W+1+REG_ADDR_W+DATA_W  oldest entry, packed {pc, instr, wr_en, wr_addr, wr_data}
trace_count  out  clog2(TRACE_DEPTH)+1  occupancy
trace_overflow  out  1  sticky; set when an entry was lost
trace_clear  in  1  synchronous flush

Behaviour:
- Reset: state RUN; core_halt=0, halted=0, halt_cause=0, all breakpoint slots disabled with address 0, trace empty, trace_count=0, trace_rd_valid=0, trace_overflow=0, resume mask clear. Reset is honoured mid-operation, with no drain.
- Breakpoint write: on bp_wr_en, the slot at bp_idx is updated at the next edge. A bp_idx at or above NUM_BP is ignored. Writes are legal in any state.
- Accepted retirement: core_valid=1 and core_halt=0. core_valid while core_halt=1 is ignored: not traced and not matched.
- FSM RUN:
  - Accepted retirement with core_pc equal to any enabled slot, and resume mask clear: go to HALTED, cause BP.
  - Otherwise, halt_req: go to HALTED, cause HOST. BP takes priority over HOST when both occur in the same cycle.
  - The matching instruction is traced. core_halt rises at the next edge, so there is 1 cycle of latency.
- FSM HALTED:
  - step_req: go to STEP and deassert core_halt.
  - Otherwise, resume_req: go to RUN, deassert core_halt, clear halt_cause, set the resume mask.
  - step_req takes priority over resume_req.
- FSM STEP: breakpoints are ignored. The first accepted retirement is traced, then the FSM goes to HALTED with cause STEP. halt_req in STEP goes to HALTED with cause HOST unless a retirement occurs in the same cycle; the retirement wins.
- Resume mask: cleared by the first accepted retirement after resume. That retirement does not check breakpoints, which lets the core leave a breakpointed PC.
- Trace write: every accepted retirement pushes one entry.
- Trace read: show-ahead. trace_rd_data is the oldest entry; trace_rd_valid = (count != 0). A pop occurs on valid && ready.
- Full trace, push without pop: the oldest entry is dropped, the read pointer advances, count stays at TRACE_DEPTH, and trace_overflow is set.
- Full trace, push and pop together: count unchanged, no overflow.
- Empty trace, push and pop together: push only; ready is ignored because valid=0.
- trace_clear: empties the buffer and clears trace_overflow. It overrides any push or pop in the same cycle; the pushed entry is lost and overflow is not set.
- Pointers wrap modulo TRACE_DEPTH.

Optional Feature:
DBG_WATCH_EN
- Defined:
  - Adds ports watch_en (in, 1), watch_addr (in, REG_ADDR_W) and watch_data (in, DATA_W).
  - In RUN, an accepted retirement with core_wr_en=1, core_wr_addr==watch_addr and core_wr_data==watch_data halts with cause WATCH.
  - Priority: BP > WATCH > HOST. The resume mask also suppresses WATCH.
- Undefined: these ports are absent and cause 4 is never produced.

Decomposition:
- Shared package dbg_pkg:
  - FSM state encoding (RUN, HALTED, STEP)
  - Cause codes (NONE, HOST, BP, STEP, WATCH)
  - Trace entry field offsets and width
- Sub-module dbg_trace_fifo: circular overwrite-on-full buffer with count, overflow and clear.
- The FSM and comparators stay in the top module.

Test Plan:
- Breakpoint: slot0=4 enabled; retire PCs 0,1,2,3,4 -> core_halt high the cycle after PC 4 retires; halted=1, cause=2; trace holds 5 entries, oldest pc=0.
- Resume off breakpoint: while halted at PC 4, pulse resume_req, then retire PC 4 then 5 -> no re-halt on PC 4; the mask clears. Retiring PC 4 again later -> halts.
- Single step: halted; pulse step_req; retire PC 6 -> HALTED, cause=3, exactly 1 new trace entry. Retire attempts while halted -> ignored, count unchanged.
- Overflow: TRACE_DEPTH=16, ready=0, 20 retirements with PCs 0..19 -> count=16, overflow=1, oldest pc=4. Then trace_clear -> count=0, overflow=0.
- Simultaneous events: slot1=9; retire PC 9 with halt_req in the same cycle -> cause=2. Full buffer with push and pop together -> count stays 16, overflow stays 0.
- Async reset: assert reset_n=0 mid-STEP with 7 entries stored -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types for the run-control / trace unit: FSM states, halt causes and
// trace entry layout {pc, instr, wr_en, wr_addr, wr_data} (LSB = wr_data).
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } dbg_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_HOST  = 3'd1,
    CAUSE_BP    = 3'd2,
    CAUSE_STEP  = 3'd3,
    CAUSE_WATCH = 3'd4
  } halt_cause_e;

  localparam int DEF_PC_W       = 16;
  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;

  function automatic int trace_entry_w(input int pc_w, input int instr_w,
                                       input int reg_w, input int data_w);
    return pc_w + instr_w + 1 + reg_w + data_w;
  endfunction

  function automatic int off_wr_data();
    return 0;
  endfunction

  function automatic int off_wr_addr(input int data_w);
    return data_w;
  endfunction

  function automatic int off_wr_en(input int data_w, input int reg_w);
    return data_w + reg_w;
  endfunction

  function automatic int off_instr(input int data_w, input int reg_w);
    return data_w + reg_w + 1;
  endfunction

  function automatic int off_pc(input int data_w, input int reg_w, input int instr_w);
    return data_w + reg_w + 1 + instr_w;
  endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Circular trace buffer: show-ahead read, overwrite-oldest on full, sticky
// overflow flag and a synchronous clear that beats any push or pop.
module dbg_trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 52,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             clear,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             mem_we;
  logic             full;
  logic             pop;

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = rd_ready && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push, pop})
        2'b10: begin
          if (full) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        2'b11: rd_ptr_d = rd_ptr_q + PTR_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/dbg_trace_unit.sv
// Run-control and trace block at the retire stage: PC breakpoints, host
// halt/resume/step and retirement trace. DBG_WATCH_EN adds a register watchpoint.
module dbg_trace_unit
  import dbg_pkg::*;
#(
  parameter  int PC_W        = DEF_PC_W,
  parameter  int INSTR_W     = DEF_INSTR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter  int NUM_BP      = 4,
  parameter  int TRACE_DEPTH = 16,
  localparam int BP_IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int TRACE_W     = trace_entry_w(PC_W, INSTR_W, REG_ADDR_W, DATA_W),
  localparam int CNT_W       = $clog2(TRACE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_valid,
  input  logic [PC_W-1:0]       core_pc,
  input  logic [INSTR_W-1:0]    core_instr,
  input  logic                  core_wr_en,
  input  logic [REG_ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0]     core_wr_data,
  output logic                  core_halt,
  input  logic                  bp_wr_en,
  input  logic [BP_IDX_W-1:0]   bp_idx,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic                  bp_enable,
  input  logic                  halt_req,
  input  logic                  resume_req,
  input  logic                  step_req,
  output logic                  halted,
  output logic [2:0]            halt_cause,
  output logic                  trace_rd_valid,
  input  logic                  trace_rd_ready,
  output logic [TRACE_W-1:0]    trace_rd_data,
  output logic [CNT_W-1:0]      trace_count,
  output logic                  trace_overflow,
  input  logic                  trace_clear,
`ifdef DBG_WATCH_EN
  input  logic                  watch_en,
  input  logic [REG_ADDR_W-1:0] watch_addr,
  input  logic [DATA_W-1:0]     watch_data,
`endif
  output logic [1:0]            dbg_state
);

  dbg_state_e        state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic              halt_q, halt_d;
  logic              mask_q, mask_d;
  logic [PC_W-1:0]   bp_addr_q [NUM_BP];
  logic [PC_W-1:0]   bp_addr_d [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q, bp_en_d;
  logic              accept;
  logic              bp_match;
  logic              watch_hit;

  // A retirement only counts while the core is allowed to retire.
  assign accept = core_valid && !halt_q;

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    if (bp_wr_en && (int'(bp_idx) < NUM_BP)) begin
      bp_addr_d[bp_idx] = bp_addr;
      bp_en_d[bp_idx]   = bp_enable;
    end
  end

  always_comb begin
    bp_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en_q[i] && (bp_addr_q[i] == core_pc)) bp_match = 1'b1;
    end
  end

`ifdef DBG_WATCH_EN
  assign watch_hit = watch_en && core_wr_en && (core_wr_addr == watch_addr) &&
                     (core_wr_data == watch_data);
`else
  assign watch_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    halt_d  = halt_q;
    mask_d  = mask_q;
    // The first retirement after a resume is exempt from matching.
    if (accept) mask_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept && bp_match && !mask_q) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
          halt_d  = 1'b1;
        end else if (accept && watch_hit && !mask_q) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_WATCH;
          halt_d  = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
          halt_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (step_req) begin
          state_d = ST_STEP;
          halt_d  = 1'b0;
        end else if (resume_req) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
          halt_d  = 1'b0;
          mask_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (accept) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
          halt_d  = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
          halt_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
        halt_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      halt_q  <= 1'b0;
      mask_q  <= 1'b0;
      bp_en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      halt_q    <= halt_d;
      mask_q    <= mask_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
    end
  end

  dbg_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .W     (TRACE_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data ({core_pc, core_instr, core_wr_en, core_wr_addr, core_wr_data}),
    .clear     (trace_clear),
    .rd_ready  (trace_rd_ready),
    .rd_valid  (trace_rd_valid),
    .rd_data   (trace_rd_data),
    .count     (trace_count),
    .overflow  (trace_overflow)
  );

  assign core_halt  = halt_q;
  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dbg_trace_unit.sv
// Bench for dbg_trace_unit: run-control vector table, trace scoreboard,
// overflow/clear sequences and asynchronous reset mid-step.
module tb_dbg_trace_unit;

  localparam int PC_W   = 16;
  localparam int RA_W   = 3;
  localparam int DEPTH  = 16;
  localparam int TW     = 52;
  localparam int CNT_W  = 5;
  localparam int NROWS  = 17;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            core_valid;
  logic [15:0]     core_pc;
  logic [15:0]     core_instr;
  logic            core_wr_en;
  logic [RA_W-1:0] core_wr_addr;
  logic [15:0]     core_wr_data;
  logic            core_halt;
  logic            bp_wr_en;
  logic [1:0]      bp_idx;
  logic [15:0]     bp_addr;
  logic            bp_enable;
  logic            halt_req;
  logic            resume_req;
  logic            step_req;
  logic            halted;
  logic [2:0]      halt_cause;
  logic            trace_rd_valid;
  logic            trace_rd_ready;
  logic [TW-1:0]   trace_rd_data;
  logic [CNT_W-1:0] trace_count;
  logic            trace_overflow;
  logic            trace_clear;
  logic [1:0]      dbg_state;
`ifdef DBG_WATCH_EN
  logic            watch_en = 1'b0;
  logic [RA_W-1:0] watch_addr = '0;
  logic [15:0]     watch_data = '0;
`endif

  dbg_trace_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_valid     (core_valid),
    .core_pc        (core_pc),
    .core_instr     (core_instr),
    .core_wr_en     (core_wr_en),
    .core_wr_addr   (core_wr_addr),
    .core_wr_data   (core_wr_data),
    .core_halt      (core_halt),
    .bp_wr_en       (bp_wr_en),
    .bp_idx         (bp_idx),
    .bp_addr        (bp_addr),
    .bp_enable      (bp_enable),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .step_req       (step_req),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .trace_rd_valid (trace_rd_valid),
    .trace_rd_ready (trace_rd_ready),
    .trace_rd_data  (trace_rd_data),
    .trace_count    (trace_count),
    .trace_overflow (trace_overflow),
    .trace_clear    (trace_clear),
`ifdef DBG_WATCH_EN
    .watch_en       (watch_en),
    .watch_addr     (watch_addr),
    .watch_data     (watch_data),
`endif
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic        bp_wr;
    logic [1:0]  bp_i;
    logic [15:0] bp_a;
    logic        bp_e;
    logic        valid;
    logic [15:0] pc;
    logic        hreq;
    logic        rreq;
    logic        sreq;
    logic        e_halt;
    logic [2:0]  e_cause;
  } vec_t;

  vec_t          tbl [NROWS];
  logic [TW-1:0] exp_q [$];
  logic          exp_halt;
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mk(input logic bw, input logic [1:0] bi, input logic [15:0] ba,
                              input logic be, input logic v, input logic [15:0] pc,
                              input logic hq, input logic rq, input logic sq,
                              input logic eh, input logic [2:0] ec);
    vec_t r;
    r.bp_wr = bw; r.bp_i = bi; r.bp_a = ba; r.bp_e = be;
    r.valid = v; r.pc = pc; r.hreq = hq; r.rreq = rq; r.sreq = sq;
    r.e_halt = eh; r.e_cause = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_valid     = 1'b0;
    halt_req       = 1'b0;
    resume_req     = 1'b0;
    step_req       = 1'b0;
    bp_wr_en       = 1'b0;
    trace_clear    = 1'b0;
  endtask

  // Drives one retirement; the model traces it only if the core is not halted.
  task automatic set_retire(input logic [15:0] pc, input bit popping);
    core_valid   = 1'b1;
    core_pc      = pc;
    core_instr   = pc ^ 16'hA5A5;
    core_wr_en   = pc[0];
    core_wr_addr = pc[2:0];
    core_wr_data = 16'($urandom_range(0, 65535));
    if (!exp_halt) begin
      if (popping && exp_q.size() > 0) void'(exp_q.pop_front());
      exp_q.push_back({core_pc, core_instr, core_wr_en, core_wr_addr, core_wr_data});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
  endtask

  task automatic bp_write(input logic [1:0] idx, input logic [15:0] a, input logic en);
    bp_wr_en  = 1'b1;
    bp_idx    = idx;
    bp_addr   = a;
    bp_enable = en;
    tick();
    idle();
  endtask

  // Scoreboard drain: pops every expected entry and compares the show-ahead data.
  task automatic drain();
    while (exp_q.size() > 0) begin
      chk("drain_valid", 64'(trace_rd_valid), 64'(1));
      chk("drain_data", 64'(trace_rd_data), 64'(exp_q.pop_front()));
      trace_rd_ready = 1'b1;
      tick();
    end
    trace_rd_ready = 1'b0;
    chk("drain_count", 64'(trace_count), 64'(0));
    chk("drain_empty", 64'(trace_rd_valid), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_halt"}, 64'(core_halt), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
    chk({tag, "_cause"}, 64'(halt_cause), 64'(0));
    chk({tag, "_count"}, 64'(trace_count), 64'(0));
    chk({tag, "_valid"}, 64'(trace_rd_valid), 64'(0));
    chk({tag, "_ovf"}, 64'(trace_overflow), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    idle();
    reset_n        = 1'b0;
    trace_rd_ready = 1'b0;
    bp_idx         = '0;
    bp_addr        = '0;
    bp_enable      = 1'b0;
    core_pc        = '0;
    core_instr     = '0;
    core_wr_en     = 1'b0;
    core_wr_addr   = '0;
    core_wr_data   = '0;
    exp_halt       = 1'b0;

    //          bw bi ba  be v  pc hq rq sq eh ec
    tbl[0]  = mk(1, 0, 4,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 1, 2, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  0, 1, 3, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,  0, 1, 4, 0, 0, 0, 1, 2);
    tbl[6]  = mk(0, 0, 0,  0, 1, 5, 0, 0, 0, 1, 2);
    tbl[7]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,  0, 1, 4, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,  0, 1, 5, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,  0, 1, 4, 0, 0, 0, 1, 2);
    tbl[11] = mk(0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 2);
    tbl[12] = mk(0, 0, 0,  0, 1, 6, 0, 0, 0, 1, 3);
    tbl[13] = mk(0, 0, 0,  0, 1, 7, 0, 0, 0, 1, 3);
    tbl[14] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(1, 1, 9,  1, 1, 8, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,  0, 1, 9, 1, 0, 0, 1, 2);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Breakpoint, resume-off-breakpoint, single step and BP-over-HOST priority
    for (int i = 0; i < NROWS; i++) begin
      bp_wr_en   = tbl[i].bp_wr;
      bp_idx     = tbl[i].bp_i;
      bp_addr    = tbl[i].bp_a;
      bp_enable  = tbl[i].bp_e;
      halt_req   = tbl[i].hreq;
      resume_req = tbl[i].rreq;
      step_req   = tbl[i].sreq;
      if (tbl[i].valid) set_retire(tbl[i].pc, 1'b0);
      else core_valid = 1'b0;
      tick();
      idle();
      chk($sformatf("row%0d_core_halt", i), 64'(core_halt), 64'(tbl[i].e_halt));
      chk($sformatf("row%0d_halted", i), 64'(halted), 64'(tbl[i].e_halt));
      chk($sformatf("row%0d_cause", i), 64'(halt_cause), 64'(tbl[i].e_cause));
      chk($sformatf("row%0d_count", i), 64'(trace_count), 64'(exp_q.size()));
      exp_halt = tbl[i].e_halt;
    end
    chk("oldest_pc", 64'(trace_rd_data[TW-1 -: PC_W]), 64'(0));
    drain();

    resume_req = 1'b1;
    tick();
    idle();
    exp_halt = 1'b0;
    chk("resume_halt", 64'(core_halt), 64'(0));
    bp_write(0, 0, 1'b0);
    bp_write(1, 0, 1'b0);

    // Overflow: 20 pushes into 16 entries with no reader
    for (int p = 0; p < 20; p++) begin
      set_retire(16'(p), 1'b0);
      tick();
      idle();
    end
    chk("ovf_count", 64'(trace_count), 64'(DEPTH));
    chk("ovf_flag", 64'(trace_overflow), 64'(1));
    chk("ovf_oldest_pc", 64'(trace_rd_data[TW-1 -: PC_W]), 64'(4));
    chk("ovf_oldest_entry", 64'(trace_rd_data), 64'(exp_q[0]));

    trace_clear = 1'b1;
    tick();
    idle();
    exp_q.delete();
    chk("clear_count", 64'(trace_count), 64'(0));
    chk("clear_ovf", 64'(trace_overflow), 64'(0));
    chk("clear_valid", 64'(trace_rd_valid), 64'(0));

    // Full buffer, push and pop in the same cycle
    for (int p = 0; p < DEPTH; p++) begin
      set_retire(16'(100 + p), 1'b0);
      tick();
      idle();
    end
    chk("full_count", 64'(trace_count), 64'(DEPTH));
    chk("full_ovf", 64'(trace_overflow), 64'(0));
    trace_rd_ready = 1'b1;
    set_retire(16'd116, 1'b1);
    tick();
    idle();
    trace_rd_ready = 1'b0;
    chk("pushpop_count", 64'(trace_count), 64'(DEPTH));
    chk("pushpop_ovf", 64'(trace_overflow), 64'(0));
    drain();

    // Empty buffer, push with ready high: push only
    trace_rd_ready = 1'b1;
    set_retire(16'd150, 1'b0);
    tick();
    idle();
    trace_rd_ready = 1'b0;
    chk("empty_pushpop_count", 64'(trace_count), 64'(1));
    drain();

    // Clear beats a simultaneous push
    set_retire(16'd200, 1'b0);
    trace_clear = 1'b1;
    tick();
    idle();
    exp_q.delete();
    chk("clear_push_count", 64'(trace_count), 64'(0));
    chk("clear_push_ovf", 64'(trace_overflow), 64'(0));

    // Async reset in STEP with 7 entries stored
    bp_write(2, 16'd30, 1'b1);
    for (int p = 0; p < 7; p++) begin
      set_retire(16'(40 + p), 1'b0);
      tick();
      idle();
    end
    halt_req = 1'b1;
    tick();
    idle();
    exp_halt = 1'b1;
    chk("host_cause", 64'(halt_cause), 64'(1));
    step_req = 1'b1;
    tick();
    idle();
    exp_halt = 1'b0;
    chk("step_state", 64'(dbg_state), 64'(2));
    chk("step_count", 64'(trace_count), 64'(7));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_halt = 1'b0;
    tick();

    // Breakpoint slots must have been cleared by the reset
    set_retire(16'd30, 1'b0);
    tick();
    idle();
    tick();
    chk("post_reset_no_bp", 64'(core_halt), 64'(0));
    chk("post_reset_count", 64'(trace_count), 64'(1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
